// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I decode into a DEPTH-entry decoded-instruction FIFO feeding EX with flush and load-use hold.
// Define ID_PERF_CNT_EN to add the illegal-instruction and hazard-hold performance counters.
module id_stage_pipe #(
  parameter int DEPTH = 2,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [11:0]     out_csr_addr,
  output logic [31:0]     out_imm,
  output logic            out_wr_reg_n,
  output logic            out_wr_csr_n,
  output logic            out_illegal_ir
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]     perf_illegal_cnt,
  output logic [31:0]     perf_hazard_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_OP = 7'h33, OP_MISC = 7'h0f, OP_SYS = 7'h73;
  logic [31:0]     ir_q  [DEPTH];
  logic [PC_W-1:0] pc_q  [DEPTH];
  logic [31:0]     imm_q [DEPTH];
  logic [2:0]      flg_q [DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic [6:0]      d_op, d_f7, h_op;
  logic [2:0]      d_f3, h_f3, d_flg;
  logic            d_csr, d_legal, d_wr_any;
  logic [31:0]     d_imm, h_ir;
  logic            ne, full, hz, use1, use2, push, pop;
  always_comb begin
    d_op = in_ir[6:0];
    d_f3 = in_ir[14:12];
    d_f7 = in_ir[31:25];
    d_csr = d_op == OP_SYS && d_f3[1:0] != 2'b00;
    d_legal = d_op == OP_LUI || d_op == OP_AUIPC || d_op == OP_JAL || d_csr
      || (d_op == OP_JALR && d_f3 == 3'd0)
      || (d_op == OP_BR && d_f3[2:1] != 2'b01)
      || (d_op == OP_LD && d_f3 != 3'd3 && d_f3 < 3'd6)
      || (d_op == OP_ST && d_f3 < 3'd3)
      || (d_op == OP_IMM && (d_f3 == 3'd1 ? d_f7 == 7'h00
                           : d_f3 == 3'd5 ? (d_f7 == 7'h00 || d_f7 == 7'h20) : 1'b1))
      || (d_op == OP_OP && (d_f7 == 7'h00 || (d_f7 == 7'h20 && (d_f3 == 3'd0 || d_f3 == 3'd5))))
      || (d_op == OP_MISC && d_f3 == 3'd0);
    d_wr_any = d_op == OP_LUI || d_op == OP_AUIPC || d_op == OP_JAL || d_op == OP_JALR
      || d_op == OP_LD || d_op == OP_IMM || d_op == OP_OP || d_csr;
    d_imm = (d_op == OP_JALR || d_op == OP_LD || d_op == OP_IMM) ? {{20{in_ir[31]}}, in_ir[31:20]}
      : d_op == OP_ST ? {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]}
      : d_op == OP_BR ? {{20{in_ir[31]}}, in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0}
      : (d_op == OP_LUI || d_op == OP_AUIPC) ? {in_ir[31:12], 12'h000}
      : d_op == OP_JAL ? {{12{in_ir[31]}}, in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0}
      : (d_csr && d_f3[2]) ? {27'd0, in_ir[19:15]} : 32'd0;
    // Read-only CSR set/clear forms (rs1 field zero) must not write the CSR.
    d_flg = {!(d_legal && d_wr_any && in_ir[11:7] != 5'd0),
             !(d_csr && !(d_f3[1] && in_ir[19:15] == 5'd0)),
             !d_legal};
  end
  assign ne = rst_n && cnt_q != '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign h_ir = ne ? ir_q[rp_q] : 32'd0;
  assign h_op = h_ir[6:0];
  assign h_f3 = h_ir[14:12];
  assign use1 = h_op == OP_JALR || h_op == OP_BR || h_op == OP_LD || h_op == OP_ST || h_op == OP_IMM
    || h_op == OP_OP || (h_op == OP_SYS && !h_f3[2] && h_f3[1:0] != 2'b00);
  assign use2 = h_op == OP_BR || h_op == OP_ST || h_op == OP_OP;
  assign hz = ld_valid && ld_rd != 5'd0
    && ((use1 && ld_rd == h_ir[19:15]) || (use2 && ld_rd == h_ir[24:20]));
  assign in_ready = rst_n && !full;
  assign out_valid = ne && !hz;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  assign out_pc = ne ? pc_q[rp_q] : '0;
  assign out_imm = ne ? imm_q[rp_q] : 32'd0;
  assign {out_wr_reg_n, out_wr_csr_n, out_illegal_ir} = ne ? flg_q[rp_q] : 3'b000;
  assign out_rs1 = h_ir[19:15];
  assign out_rs2 = h_ir[24:20];
  assign out_rd = h_ir[11:7];
  assign out_opcode = h_op;
  assign out_funct3 = h_f3;
  assign out_funct7 = h_ir[31:25];
  assign out_csr_addr = h_ir[31:20];
  always_ff @(posedge clk) begin
    if (push) begin
      ir_q[wp_q] <= in_ir;
      pc_q[wp_q] <= in_pc;
      imm_q[wp_q] <= d_imm;
      flg_q[wp_q] <= d_flg;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_illegal_cnt <= 32'd0;
      perf_hazard_cnt <= 32'd0;
    end else begin
      perf_illegal_cnt <= perf_illegal_cnt + 32'(push && d_flg[0]);
      perf_hazard_cnt <= perf_hazard_cnt + 32'(ne && hz);
    end
  end
`endif
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered, buffered successor to the combinational RV32I decode stage. Each instruction accepted on a valid/ready input is decoded (fields, immediate, write enables, legality) and written into a DEPTH-entry decoded-instruction FIFO. The FIFO feeds EX over a valid/ready output and supports flush and load-use hazard hold. The block sits between IF and EX.

Parameters:
DEPTH, 2, number of decoded entries buffered; power of two, minimum 2
PC_W, 32, width of the program-counter sideband

Ports:
clk  in  1  clock; everything updates on the rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage can accept; equals !full
in_ir  in  32  instruction word
in_pc  in  PC_W  instruction PC
flush  in  1  discard all buffered entries and the current input
ld_valid  in  1  a load is in EX this cycle
ld_rd  in  5  destination register of that load
out_valid  out  1  head entry valid and not hazard-held
out_ready  in  1  EX accepts the head entry
out_pc  out  PC_W  head PC
out_rs1, out_rs2, out_rd  out  5 each  register fields
out_opcode  out  7  opcode
out_funct3  out  3  funct3
out_funct7  out  7  funct7
out_csr_addr  out  12  ir[31:20]
out_imm  out  32  decoded immediate
out_wr_reg_n  out  1  0 = write rd
out_wr_csr_n  out  1  0 = write CSR
out_illegal_ir  out  1  1 = illegal instruction

Behaviour:
- Reset: while rst_n=0 at a clock edge, the FIFO empties and both pointers clear. in_ready=0 during reset. out_valid=0 and every out_* field reads 0.
- Push condition: in_valid & in_ready & !flush. Pop condition: out_valid & out_ready. A simultaneous push and pop when not full is legal; occupancy is unchanged.
- Full: in_ready=0, so there is no pass-through when full. Empty: out_valid=0 and out_* hold 0.
- Latency: an instruction pushed at edge N is visible at the head after edge N when the FIFO was empty. There is no combinational path from in_* to out_*.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- flush: at the edge, pointers and count go to 0. Any push in that cycle is dropped. A pop in that cycle is ignored (EX is flushing too).
- Load-use hold:
  - Hazard when ld_valid=1, ld_rd≠0, and ld_rd equals a head source that is used.
  - While a hazard exists, out_valid=0 and the head is held.
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and CSR with funct3[2]=0.
  - rs2 is used by BRANCH, STORE, and OP.
- Immediate encoding (sign-extended from ir[31] unless noted):
  - I-type: JALR, LOAD, OP-IMM.
  - S-type: STORE.
  - B-type: BRANCH, bit0=0.
  - U-type: LUI, AUIPC, low 12 bits=0.
  - J-type: JAL, bit0=0.
  - CSR with funct3[2]=1: zero-extended rs1 field.
  - All other opcodes: 0.
- Legality (illegal_ir=1 otherwise):
  - LUI, AUIPC, JAL: always legal.
  - JALR: funct3=000.
  - BRANCH: funct3 not 010 or 011.
  - LOAD: funct3 in {000,001,010,100,101}.
  - STORE: funct3 in {000,001,010}.
  - OP-IMM: funct3=001 requires funct7=0000000; funct3=101 requires funct7 in {0000000,0100000}.
  - OP: funct7=0000000, or funct7=0100000 with funct3 in {000,101}.
  - MISC-MEM: funct3=000.
  - SYSTEM: funct3=000 is flagged illegal so the trap path handles ECALL/EBREAK; funct3=100 is illegal; all other funct3 values are legal CSR ops.
  - Any other opcode is illegal.
- wr_reg_n=0 only when all three hold:
  - the instruction is legal;
  - rd≠0;
  - the opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, or a CSR op.
- wr_csr_n=0 only for legal CSR ops, except CSRRS/CSRRC/CSRRSI/CSRRCI (funct3 in {010,011,110,111}) with rs1 field=0, which are read-only and give wr_csr_n=1.

Optional Feature:
ID_PERF_CNT_EN: adds two outputs, perf_illegal_cnt[31:0] and perf_hazard_cnt[31:0].
- perf_illegal_cnt: +1 per pushed entry with illegal_ir=1.
- perf_hazard_cnt: +1 per cycle a non-empty head is hazard-held.
- Both wrap at 2^32, clear on reset, and are not cleared by flush.
Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then push ADDI x3,x1,0x801 (0x80108193) with out_ready=1 -> next cycle out_valid=1, rd=3, rs1=1, imm=FFFFF801, wr_reg_n=0, illegal_ir=0.
- out_ready=0, push 3 instructions with DEPTH=2 -> in_ready falls after 2 pushes and the third is not accepted; release out_ready -> the two entries pop in order, then in_ready=1.
- Head LW x5,0(x2) then ADD x6,x5,x7 with ld_valid=1, ld_rd=5 -> out_valid=0 while held; drop ld_valid -> ADD issues. With ld_rd=0 -> no hold.
- flush asserted with 2 entries and in_valid=1 -> next cycle out_valid=0, count=0, and the pushed instruction is absent.
- CSRRS x2,0x300,x0 (0x30002173) -> csr_addr=300, wr_csr_n=1, illegal_ir=0. CSRRW x2,0x300,x1 (0x30009173) -> wr_csr_n=0. funct3=100 -> illegal_ir=1, wr_reg_n=1.
- JAL x0,+2 (0x0020006F) -> imm=2, wr_reg_n=1. BEQ with funct3=010 -> illegal_ir=1. With ID_PERF_CNT_EN, after these -> perf_illegal_cnt=2.
